// File: rtl/vga_text_fetch_if.sv
// vga_text_fetch_if: video timing, text RAM and font ROM signals
// master is the fetch engine, slave is the memories and display side
interface vga_text_fetch_if;
  logic        pixEn;
  logic        hSync;
  logic        vSync;
  logic        bright;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic [11:0] charAddr;
  logic [7:0]  charData;
  logic [11:0] fontAddr;
  logic [7:0]  fontData;
  logic [7:0]  pixelRow;
  logic [2:0]  glyphX;
  logic        frameStart;

  modport master (
    output pixEn, hSync, vSync, bright,
    output hCount, vCount,
    output charAddr, fontAddr,
    output pixelRow, glyphX, frameStart,
    input  charData, fontData
  );

  modport slave (
    input  pixEn, hSync, vSync, bright,
    input  hCount, vCount,
    input  charAddr, fontAddr,
    input  pixelRow, glyphX, frameStart,
    output charData, fontData
  );
endinterface

// File: rtl/vga_text_fetch.sv
// vga_text_fetch: VGA timing with an 80x30 text-mode glyph fetch
// two pixel-tick pipeline: text RAM read, then font ROM read
module vga_text_fetch #(
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_VIS   = 640,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_VIS   = 480,
  parameter int V_TOTAL = 525
) (
  input  logic clk,
  input  logic rst_n,
  vga_text_fetch_if.master bus
);

  localparam logic [9:0] HS_W   = 10'(H_SYNC);
  localparam logic [9:0] HV_LO  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HV_HI  = 10'(H_SYNC + H_BP + H_VIS);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] VS_W   = 10'(V_SYNC);
  localparam logic [9:0] VV_LO  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VV_HI  = 10'(V_SYNC + V_BP + V_VIS);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  typedef struct packed {
    logic [7:0] chr;
    logic [3:0] gline;
    logic [2:0] gx;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
  } s1_t;

  typedef struct packed {
    logic [7:0] row;
    logic [2:0] gx;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
  } s2_t;

  // sync outputs idle high while the pipe is empty
  localparam s1_t S1_RST = '{
    chr: 8'd0, gline: 4'd0, gx: 3'd0,
    h: 10'd0, v: 10'd0,
    hs: 1'b1, vs: 1'b1, br: 1'b0
  };

  localparam s2_t S2_RST = '{
    row: 8'd0, gx: 3'd0,
    h: 10'd0, v: 10'd0,
    hs: 1'b1, vs: 1'b1, br: 1'b0
  };

  logic        pix;
  logic [9:0]  h;
  logic [9:0]  v;
  logic [9:0]  hd;
  logic [9:0]  vd;
  logic        hs_raw;
  logic        vs_raw;
  logic        br_raw;
  logic [11:0] addr;
  s1_t         s1;
  s1_t         s1_n;
  s2_t         s2;
  s2_t         s2_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix <= 1'b0;
    else        pix <= ~pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= 10'd0;
      v <= 10'd0;
    end else if (pix) begin
      if (h == H_LAST) begin
        h <= 10'd0;
        v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign hd = h - HV_LO;
  assign vd = v - VV_LO;

  assign hs_raw = (h >= HS_W);
  assign vs_raw = (v >= VS_W);
  assign br_raw = (h >= HV_LO) && (h < HV_HI) &&
                  (v >= VV_LO) && (v < VV_HI);

  // 16-line cells vertically, 8-pixel cells horizontally
  assign addr = br_raw
    ? ({6'd0, vd[9:4]} * 12'd80) + {5'd0, hd[9:3]}
    : 12'd0;

  assign s1_n = '{
    chr: bus.charData, gline: vd[3:0], gx: hd[2:0],
    h: h, v: v,
    hs: hs_raw, vs: vs_raw, br: br_raw
  };

  assign s2_n = '{
    row: s1.br ? bus.fontData : 8'h00,
    gx: s1.gx, h: s1.h, v: s1.v,
    hs: s1.hs, vs: s1.vs, br: s1.br
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   s1 <= S1_RST;
    else if (pix) s1 <= s1_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   s2 <= S2_RST;
    else if (pix) s2 <= s2_n;
  end

  assign bus.pixEn      = pix;
  assign bus.charAddr   = addr;
  assign bus.fontAddr   = {s1.chr, s1.gline};
  assign bus.frameStart = pix && (h == 10'd0) && (v == 10'd0);
  assign bus.pixelRow   = s2.row;
  assign bus.glyphX     = s2.gx;
  assign bus.hCount     = s2.h;
  assign bus.vCount     = s2.v;
  assign bus.hSync      = s2.hs;
  assign bus.vSync      = s2.vs;
  assign bus.bright     = s2.br;

endmodule
